// File: rtl/zimbo_pkg.sv
// Shared constants for the zimbo core: opcodes, sequencer state encoding
// and the pc_sel / addrbase select codes.
package zimbo_pkg;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00001;
    localparam logic [4:0] OP_LW   = 5'b00010;
    localparam logic [4:0] OP_SW   = 5'b00011;
    localparam logic [4:0] OP_BEQ  = 5'b00100;
    localparam logic [4:0] OP_JMP  = 5'b00101;
    localparam logic [4:0] OP_MUL  = 5'b00110;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [1:0] PC_SEL_INC    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

    localparam logic [1:0] ADDR_R0    = 2'd0;
    localparam logic [1:0] ADDR_IR    = 2'd1;
    localparam logic [1:0] ADDR_ADDR2 = 2'd2;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_WB_HI,
        ST_HALT
    } state_t;

    // Opcodes that continue into the EXEC state after DECODE.
    function automatic logic goes_exec(input logic [4:0] op);
        return (op == OP_ALU) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW)  || (op == OP_BEQ)  || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory and
// register write-back control for the zimbo datapath.
//
// state     | meaning
// FETCH     | instruction read, waits for mem_ready, loads IR and bumps PC
// DECODE    | opcode/func captured, JMP taken here, illegal/HALT detected
// EXEC      | ALU operation; BEQ resolves here
// MEM       | data read (LW) or write (SW), waits for mem_ready
// WB        | register write-back (low half for MUL)
// WB_HI     | MUL high half write-back
// HALT      | absorbing stop until reset
import zimbo_pkg::*;

module control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] opcode,
    input  logic [2:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_en,
    output logic       pc_en,
    output logic [1:0] pc_sel,
    output logic       mem_re,
    output logic       mem_we,
    output logic       insdat,
    output logic       rf_we,
    output logic       mem_alu,
    output logic [1:0] addrbase,
    output logic       mulreg,
    output logic       alusrc,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic       illegal
);

    state_t     state_q, state_d;
    logic [4:0] op_q;
    logic [2:0] func_q;
    logic       illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            op_q      <= '0;
            func_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q   <= opcode;
                func_q <= func;
                if (!goes_exec(opcode) && opcode != OP_JMP && opcode != OP_HALT)
                    illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (goes_exec(opcode))     state_d = ST_EXEC;
                else if (opcode == OP_JMP) state_d = ST_FETCH;
                else                       state_d = ST_HALT;
            end
            ST_EXEC: begin
                if (op_q == OP_LW || op_q == OP_SW) state_d = ST_MEM;
                else if (op_q == OP_BEQ)            state_d = ST_FETCH;
                else                                state_d = ST_WB;
            end
            ST_MEM: begin
                if (mem_ready) state_d = (op_q == OP_LW) ? ST_WB : ST_FETCH;
            end
            ST_WB:    state_d = (op_q == OP_MUL) ? ST_WB_HI : ST_FETCH;
            ST_WB_HI: state_d = ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    // Gated by rst_n so everything reads quiet while reset is held,
    // even though the state register already sits in FETCH.
    always_comb begin
        ir_en    = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = PC_SEL_INC;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        insdat   = 1'b0;
        rf_we    = 1'b0;
        mem_alu  = 1'b0;
        addrbase = ADDR_R0;
        mulreg   = 1'b0;
        alusrc   = 1'b0;
        alu_op   = ALU_ADD;
        halted   = 1'b0;
        illegal  = 1'b0;
        if (rst_n) begin
            illegal = illegal_q;
            case (state_q)
                ST_FETCH: begin
                    mem_re = 1'b1;
                    ir_en  = mem_ready;
                    pc_en  = mem_ready;
                end
                ST_DECODE: begin
                    if (opcode == OP_JMP) begin
                        pc_en  = 1'b1;
                        pc_sel = PC_SEL_JUMP;
                    end
                end
                ST_EXEC: begin
                    if (op_q == OP_ALU || op_q == OP_MUL) begin
                        alu_op = func_q;
                        alusrc = 1'b1;
                    end else if (op_q == OP_BEQ) begin
                        alu_op = ALU_SUB;
                        alusrc = 1'b1;
                        if (zero) begin
                            pc_en  = 1'b1;
                            pc_sel = PC_SEL_BRANCH;
                        end
                    end
                end
                ST_MEM: begin
                    insdat = 1'b1;
                    mem_re = (op_q == OP_LW);
                    mem_we = (op_q == OP_SW);
                end
                ST_WB: begin
                    rf_we    = 1'b1;
                    addrbase = ADDR_IR;
                    mem_alu  = (op_q == OP_LW);
                end
                ST_WB_HI: begin
                    rf_we    = 1'b1;
                    addrbase = ADDR_ADDR2;
                    mulreg   = 1'b1;
                end
                ST_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Cycle-accurate scoreboard bench for control_fsm: each instruction queues
// its per-cycle stimulus and expected control word, then the queue is drained.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] opcode;
    logic [2:0] func;
    logic       zero;
    logic       mem_ready;
    logic       ir_en, pc_en, mem_re, mem_we, insdat, rf_we, mem_alu;
    logic       mulreg, alusrc, halted, illegal;
    logic [1:0] pc_sel, addrbase;
    logic [2:0] alu_op;

    int vectors = 0;
    int miscompares = 0;
    logic exp_illegal = 1'b0;

    typedef struct packed {
        logic       ir_en;
        logic       pc_en;
        logic [1:0] pc_sel;
        logic       mem_re;
        logic       mem_we;
        logic       insdat;
        logic       rf_we;
        logic       mem_alu;
        logic [1:0] addrbase;
        logic       mulreg;
        logic       alusrc;
        logic [2:0] alu_op;
        logic       halted;
        logic       illegal;
    } out_t;

    typedef struct {
        logic       mr;
        logic       z;
        logic [4:0] op;
        logic [2:0] fn;
        out_t       exp;
        string      tag;
    } vec_t;

    vec_t sb[$];

    control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel),
        .mem_re(mem_re), .mem_we(mem_we), .insdat(insdat), .rf_we(rf_we),
        .mem_alu(mem_alu), .addrbase(addrbase), .mulreg(mulreg),
        .alusrc(alusrc), .alu_op(alu_op), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic out_t sample();
        out_t o;
        o.ir_en = ir_en;     o.pc_en = pc_en;   o.pc_sel = pc_sel;
        o.mem_re = mem_re;   o.mem_we = mem_we; o.insdat = insdat;
        o.rf_we = rf_we;     o.mem_alu = mem_alu; o.addrbase = addrbase;
        o.mulreg = mulreg;   o.alusrc = alusrc; o.alu_op = alu_op;
        o.halted = halted;   o.illegal = illegal;
        return o;
    endfunction

    function automatic out_t blank();
        out_t o = '0;
        o.illegal = exp_illegal;
        return o;
    endfunction

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic mr, input logic z, input logic [4:0] op,
                        input logic [2:0] fn, input out_t e, input string tag);
        vec_t v;
        v.mr = mr; v.z = z; v.op = op; v.fn = fn; v.exp = e; v.tag = tag;
        sb.push_back(v);
    endtask

    // After DECODE the opcode/func inputs are scrambled: the DUT must use its captured copy.
    task automatic push_instr(input logic [4:0] op, input logic [2:0] fn, input logic z,
                              input int fwait, input int mwait, input string tag);
        out_t o;
        logic legal;
        logic is_lw, is_sw, is_beq, is_mul;
        legal  = (op <= 5'd4) || (op == 5'd6);
        is_lw  = (op == 5'd2);
        is_sw  = (op == 5'd3);
        is_beq = (op == 5'd4);
        is_mul = (op == 5'd6);
        for (int i = 0; i < fwait; i++) begin
            o = blank(); o.mem_re = 1'b1;
            push(1'b0, z, op, fn, o, {tag, ".fetch_wait"});
        end
        o = blank(); o.mem_re = 1'b1; o.ir_en = 1'b1; o.pc_en = 1'b1;
        push(1'b1, z, op, fn, o, {tag, ".fetch"});
        o = blank();
        if (op == 5'd5) begin o.pc_en = 1'b1; o.pc_sel = 2'd2; end
        push(rbit(), z, op, fn, o, {tag, ".decode"});
        if (!legal) begin
            if (op != 5'd5 && op != 5'd31) exp_illegal = 1'b1;
            return;
        end
        o = blank();
        o.alu_op = (op == 5'd0 || is_mul) ? fn : (is_beq ? 3'b001 : 3'b000);
        o.alusrc = (op == 5'd0) || is_mul || is_beq;
        if (is_beq && z) begin o.pc_en = 1'b1; o.pc_sel = 2'd1; end
        push(rbit(), z, 5'($urandom), 3'($urandom), o, {tag, ".exec"});
        if (is_beq) return;
        if (is_lw || is_sw) begin
            o = blank(); o.insdat = 1'b1; o.mem_re = is_lw; o.mem_we = is_sw;
            for (int i = 0; i < mwait; i++)
                push(1'b0, z, 5'($urandom), 3'($urandom), o, {tag, ".mem_wait"});
            push(1'b1, z, 5'($urandom), 3'($urandom), o, {tag, ".mem"});
            if (is_sw) return;
        end
        o = blank(); o.rf_we = 1'b1; o.addrbase = 2'd1; o.mem_alu = is_lw;
        push(rbit(), z, 5'($urandom), 3'($urandom), o, {tag, ".wb"});
        if (is_mul) begin
            o = blank(); o.rf_we = 1'b1; o.addrbase = 2'd2; o.mulreg = 1'b1;
            push(rbit(), z, 5'($urandom), 3'($urandom), o, {tag, ".wb_hi"});
        end
    endtask

    task automatic push_halt(input int n, input string tag);
        out_t o;
        for (int i = 0; i < n; i++) begin
            o = blank(); o.halted = 1'b1;
            push(rbit(), rbit(), 5'($urandom), 3'($urandom), o, tag);
        end
    endtask

    task automatic drain(input int leave);
        vec_t v;
        while (sb.size() > leave) begin
            v = sb.pop_front();
            @(negedge clk);
            mem_ready = v.mr; zero = v.z; opcode = v.op; func = v.fn;
            #1;
            chk(v.tag, sample(), v.exp);
        end
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk({tag, ".in_reset"}, sample(), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, ".held_reset"}, sample(), 32'd0);
        exp_illegal = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        begin
            out_t o = blank();
            o.mem_re = 1'b1;
            chk({tag, ".after_release"}, sample(), o);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        opcode = 5'd0; func = 3'd0; zero = 1'b0; mem_ready = 1'b1;
        #12;
        chk("por", sample(), 32'd0);
        apply_reset("init");

        push_instr(5'd0, 3'b000, 1'b0, 0, 0, "add");
        push_instr(5'd0, 3'b101, 1'b1, 2, 0, "alu_f5");
        push_instr(5'd1, 3'b111, 1'b0, 0, 0, "addi");
        push_instr(5'd2, 3'b010, 1'b0, 0, 3, "lw_wait3");
        push_instr(5'd2, 3'b000, 1'b1, 1, 0, "lw");
        push_instr(5'd3, 3'b011, 1'b0, 0, 0, "sw");
        push_instr(5'd3, 3'b110, 1'b1, 0, 2, "sw_wait2");
        push_instr(5'd4, 3'b100, 1'b1, 0, 0, "beq_taken");
        push_instr(5'd4, 3'b100, 1'b0, 0, 0, "beq_fall");
        push_instr(5'd6, 3'b011, 1'b0, 0, 0, "mul");
        push_instr(5'd5, 3'b000, 1'b1, 0, 0, "jmp");
        push_instr(5'd0, 3'b110, 1'b0, 0, 0, "alu_f6");
        push_instr(5'd31, 3'b000, 1'b0, 0, 0, "halt_op");
        push_halt(5, "halt");
        drain(0);
        apply_reset("rst_after_halt");

        push_instr(5'd15, 3'b000, 1'b0, 0, 0, "illegal_op");
        push_halt(20, "illegal_halt");
        drain(0);
        chk("illegal_sticky", {31'd0, illegal}, 32'd1);
        apply_reset("rst_after_illegal");

        push_instr(5'd3, 3'b000, 1'b0, 0, 3, "sw_abort");
        drain(1);
        sb.delete();
        chk("sw_abort.mem_we_before", {31'd0, mem_we}, 32'd1);
        apply_reset("rst_mid_sw");

        push_instr(5'd0, 3'b010, 1'b0, 0, 0, "add_post");
        push_instr(5'd6, 3'b001, 1'b1, 1, 0, "mul_post");
        drain(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port opcode, input, 5, instruction opcode (IR[15:11]).
REQ-004 SHALL have port func, input, 3, ALU sub-function (IR[2:0]).
REQ-005 SHALL have port zero, input, 1, ALU result-equals-zero flag.
REQ-006 SHALL have port mem_ready, input, 1, memory access complete this cycle.
REQ-007 SHALL have outputs ir_en (1), pc_en (1), pc_sel (2: 0 = pc+2, 1 = branch, 2 = jump), each 1 cycle wide.
REQ-008 SHALL have outputs mem_re, mem_we, insdat (1 = data address, 0 = PC), each 1 bit.
REQ-009 SHALL have outputs rf_we (1), mem_alu (1 = memory write-back), addrbase (2: 0 = R0, 1 = IR[6:3], 2 = addr2), mulreg (1), alusrc (1 = register, 0 = immediate).
REQ-010 SHALL have outputs alu_op (3), halted (1), illegal (1).

Function
REQ-011 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, WB_HI, HALT.
REQ-012 FETCH SHALL assert mem_re with insdat=0 and hold until mem_ready; on mem_ready it SHALL pulse ir_en and pc_en with pc_sel=0, then go to DECODE.
REQ-013 DECODE SHALL go to EXEC for ALU (00000), ADDI (00001), LW (00010), SW (00011), BEQ (00100) and MUL (00110).
REQ-014 In DECODE, JMP (00101) SHALL pulse pc_en with pc_sel=2 and return to FETCH.
REQ-015 In DECODE, HALT (11111) SHALL go to HALT.
REQ-016 In DECODE, any other opcode SHALL set the sticky illegal flag and go to HALT.
REQ-017 EXEC SHALL drive alu_op=func for ALU and MUL, 3'b000 (add) for ADDI/LW/SW, and 3'b001 (sub) for BEQ.
REQ-018 EXEC SHALL drive alusrc=1 for ALU, MUL and BEQ, and 0 otherwise.
REQ-019 EXEC SHALL go to WB for ALU/ADDI, MEM for LW/SW, and WB for MUL.
REQ-020 For BEQ, EXEC SHALL pulse pc_en with pc_sel=1 only when zero=1, then go to FETCH; fall-through costs no extra cycle.
REQ-021 MEM SHALL assert insdat=1 plus mem_re (LW) or mem_we (SW) and hold until mem_ready.
REQ-022 On mem_ready in MEM, LW SHALL go to WB and SW SHALL go to FETCH.
REQ-023 WB SHALL pulse rf_we with addrbase=1; mem_alu=1 only for LW.
REQ-024 For MUL, WB SHALL drive mulreg=0 and go to WB_HI; WB_HI SHALL pulse rf_we with addrbase=2 and mulreg=1, then go to FETCH.
REQ-025 All outputs SHALL be decoded from the registered state plus a registered copy of opcode/func captured in DECODE, and SHALL be glitch-free relative to clk.
REQ-026 Latency with mem_ready tied high SHALL be 4 cycles for ALU/ADDI, SW 4, LW 5, MUL 5, BEQ 3 and JMP 2.
REQ-027 HALT SHALL be absorbing: halted=1 and all enables 0 until reset.
REQ-028 mem_ready asserted outside FETCH or MEM SHALL be ignored.
REQ-029 At most one of rf_we, mem_we and ir_en SHALL be high in any cycle.

Reset
REQ-030 Asserting rst_n low SHALL asynchronously force state FETCH and clear illegal, halted and the opcode/func registers.
REQ-031 While rst_n is low, every enable output SHALL read 0; pc_sel, addrbase and alu_op 0; mulreg, insdat, alusrc and mem_alu 0.
REQ-032 Reset mid-access SHALL abandon the transaction; the first cycle after release SHALL be FETCH with mem_re=1.

Structure
REQ-033 Opcode constants, state encoding and pc_sel/addrbase codes SHALL live in the shared package zimbo_pkg.
REQ-034 The block SHALL be a single module: one state register, one next-state process and one output decode; no sub-module.

Verification
REQ-035 ADD (00000, func 000) with mem_ready=1 -> ir_en at cycle 1, rf_we at cycle 4 with addrbase=1, mem_alu=0, then FETCH.
REQ-036 LW with mem_ready low for 3 cycles in MEM -> mem_re and insdat=1 held for 4 cycles, then rf_we with mem_alu=1.
REQ-037 BEQ with zero=1, then with zero=0 -> pc_en with pc_sel=1 in EXEC only in the first case; both return to FETCH after 3 cycles.
REQ-038 MUL -> two consecutive rf_we pulses: mulreg=0/addrbase=1, then mulreg=1/addrbase=2.
REQ-039 Opcode 01111 -> illegal=1, halted=1; all enables stay 0 for 20 cycles despite mem_ready toggling.
REQ-040 rst_n pulsed low during an SW MEM wait -> mem_we drops immediately; after release, FETCH with mem_re=1 and illegal=0.
